stream_packet_fifo: RTL

Store-and-forward Avalon-ST packet FIFO placed directly downstream of the endian swapper stage. It absorbs complete packets from the swapper's output stream and presents them to the next consumer only once the end-of-packet word is stored, so downstream never sees a partially stored packet, except in the oversize-packet case below. An Avalon-MM CSR port exposes the fill level and packet counters and provides a flush control.

---
 rtl/stream_packet_fifo.sv | 139 +++++++++++++
 1 files changed

// File: rtl/stream_packet_fifo.sv
// stream_packet_fifo
//   Store-and-forward Avalon-ST packet FIFO with an Avalon-MM CSR port.
//   A packet is offered downstream only after its EOP word has been stored.
//   The one exception is a completely full FIFO with no EOP stored: it streams
//   out cut-through so a packet longer than DEPTH cannot deadlock.
//
// Optional feature macro: STREAM_PACKET_FIFO_STATS_EN
//   defined     -> 32-bit wrapping count of popped EOP words, readable at CSR 2
//   not defined -> no counter, CSR 2 reads 0
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   stream_in_*             Avalon-ST sink   (data/empty/valid/sop/eop/ready)
//   stream_out_*            Avalon-ST source (show-ahead head of FIFO)
//   csr_*                   Avalon-MM slave, readLatency 1
//     0 RO fill   1 RO pkt_stored   2 RO total popped   3 WO bit0 = flush
module stream_packet_fifo #(
  parameter int DATA_BYTES = 8,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BYTES*8-1:0]       stream_in_data,
  input  logic [$clog2(DATA_BYTES)-1:0] stream_in_empty,
  input  logic                          stream_in_valid,
  input  logic                          stream_in_startofpacket,
  input  logic                          stream_in_endofpacket,
  output logic                          stream_in_ready,
  output logic [DATA_BYTES*8-1:0]       stream_out_data,
  output logic [$clog2(DATA_BYTES)-1:0] stream_out_empty,
  output logic                          stream_out_valid,
  output logic                          stream_out_startofpacket,
  output logic                          stream_out_endofpacket,
  input  logic                          stream_out_ready,
  input  logic [1:0]                    csr_address,
  input  logic                          csr_read,
  input  logic                          csr_write,
  input  logic [31:0]                   csr_writedata,
  output logic [31:0]                   csr_readdata,
  output logic                          csr_readdatavalid,
  output logic                          csr_waitrequest
);
  localparam int DW = DATA_BYTES * 8;
  localparam int EW = $clog2(DATA_BYTES);
  localparam int AW = $clog2(DEPTH);
  localparam int MW = DW + EW + 2;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // entry layout: {data, empty, sop, eop}
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] head;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fill, pkt_stored;
  logic          full, push, pop, flush, push_eop, pop_eop;
  logic [31:0]   total_view, rd_mux;

  assign full  = (fill == FULL);
  assign head  = mem[rd_ptr];

  assign stream_in_ready  = reset_n & ~full;
  // reset_n gating keeps valid low throughout the reset cycle itself
  assign stream_out_valid = reset_n & (fill != '0) & ((pkt_stored != '0) | full);

  assign stream_out_data          = head[MW-1 -: DW];
  assign stream_out_empty         = head[EW+1:2];
  assign stream_out_startofpacket = head[1];
  assign stream_out_endofpacket   = head[0];

  assign push     = stream_in_valid & stream_in_ready;
  assign pop      = stream_out_valid & stream_out_ready;
  assign flush    = csr_write & (csr_address == 2'd3) & csr_writedata[0];
  assign push_eop = push & stream_in_endofpacket;
  assign pop_eop  = pop & head[0];

  assign csr_waitrequest = ~reset_n;

  // storage carries no reset; contents are qualified by fill
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= {stream_in_data, stream_in_empty,
                      stream_in_startofpacket, stream_in_endofpacket};
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      pkt_stored <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fill <= fill + 1'b1;
      else if (pop && !push) fill <= fill - 1'b1;
      if (push_eop && !pop_eop)      pkt_stored <= pkt_stored + 1'b1;
      else if (pop_eop && !push_eop) pkt_stored <= pkt_stored - 1'b1;
    end
  end

`ifdef STREAM_PACKET_FIFO_STATS_EN
  logic [31:0] total_popped;

  // a pop discarded by a same-cycle flush is not counted
  always_ff @(posedge clk) begin
    if (!reset_n)                total_popped <= '0;
    else if (pop_eop && !flush)  total_popped <= total_popped + 1'b1;
  end

  assign total_view = total_popped;
`else
  assign total_view = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      2'd0:    rd_mux = 32'(fill);
      2'd1:    rd_mux = 32'(pkt_stored);
      2'd2:    rd_mux = total_view;
      default: rd_mux = '0;
    endcase
  end

  // sampled from pre-edge state, so a read alongside a flush sees old values
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      csr_readdata      <= '0;
      csr_readdatavalid <= 1'b0;
    end else begin
      csr_readdatavalid <= csr_read;
      if (csr_read) csr_readdata <= rd_mux;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^csr_writedata[31:1];

endmodule
